// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction prefetch queue: default widths,
// fetch FSM encoding and the packed {pc, inst} FIFO entry width.
package fetch_pkg;

   localparam int XLEN_DEF   = 64;
   localparam int INST_W_DEF = 32;
   localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = 64'h0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

   function automatic int entry_w(input int xlen, input int inst_w);
      return xlen + inst_w;
   endfunction

   // Width of one queued entry, packed as {pc, inst}.
   localparam int ENTRY_W = entry_w(XLEN_DEF, INST_W_DEF);

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with combinational head read and a flush that
// overrides push and pop. Head reads as zero while the FIFO is empty.
module fetch_fifo #(
   parameter int WIDTH = 96,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic [WIDTH-1:0]         head_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_push;
   logic             do_pop;
   logic             empty;

   assign empty   = (count_q == '0);
   assign do_pop  = pop_i && !empty;
   assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
            2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage is a register file so the head is visible in the cycle after a push.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
         if (do_push && !flush_i && (wr_ptr_q == PTR_W'(gi))) begin
            mem_q[gi] <= wdata_i;
         end
      end
   end

   assign count_o = count_q;
   assign head_o  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetcher: one outstanding imem request, responses
// queued with their PCs, flush-and-refetch on redirect from execute.
module fetch_prefetch_queue
   import fetch_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int INST_W = INST_W_DEF,
   parameter int DEPTH  = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [XLEN-1:0]   imem_addr,
   input  logic              imem_ack,
   input  logic [INST_W-1:0] imem_rdata,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic              inst_valid,
   output logic [INST_W-1:0] inst,
   output logic [XLEN-1:0]   inst_pc,
   output logic [XLEN-1:0]   inst_pc4,
   input  logic              inst_ready
);

   localparam int E_W   = entry_w(XLEN, INST_W);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   fetch_state_e     state_q;
   logic             req_q;
   logic [XLEN-1:0]  addr_q;
   logic [XLEN-1:0]  fetch_pc_q;

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic [E_W-1:0]   head;
   logic             push;
   logic             pop;
   logic             space_free;
   logic [XLEN-1:0]  target_pc;

   assign inst_valid = (count != '0);
   assign pop        = inst_valid && inst_ready;
   assign push       = imem_ack && (state_q == WAIT) && !redirect_valid;
   assign count_next = redirect_valid ? '0
                     : count + CNT_W'(push) - CNT_W'(pop);
   // A request only goes out when its response is guaranteed a slot.
   assign space_free = (count_next < DEPTH_CNT);
   assign target_pc  = redirect_pc & ~XLEN'(3);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         req_q      <= 1'b0;
         addr_q     <= RESET_PC;
         fetch_pc_q <= RESET_PC;
      end else begin
         if (redirect_valid)  fetch_pc_q <= target_pc;
         else if (push)       fetch_pc_q <= addr_q + XLEN'(4);

         case (state_q)
            IDLE: begin
               if (!redirect_valid && space_free) begin
                  state_q <= WAIT;
                  req_q   <= 1'b1;
                  addr_q  <= fetch_pc_q;
               end
            end
            WAIT: begin
               if (redirect_valid) begin
                  if (imem_ack) begin
                     state_q <= IDLE;
                     req_q   <= 1'b0;
                  end else begin
                     state_q <= DRAIN;
                  end
               end else if (imem_ack) begin
                  if (space_free) begin
                     addr_q <= addr_q + XLEN'(4);
                  end else begin
                     state_q <= IDLE;
                     req_q   <= 1'b0;
                  end
               end
            end
            DRAIN: begin
               if (imem_ack) begin
                  state_q <= IDLE;
                  req_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   fetch_fifo #(
      .WIDTH (E_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (redirect_valid),
      .wdata_i ({addr_q, imem_rdata}),
      .count_o (count),
      .head_o  (head)
   );

   assign imem_req  = req_q;
   assign imem_addr = addr_q;
   assign inst      = head[INST_W-1:0];
   assign inst_pc   = head[E_W-1:INST_W];
   assign inst_pc4  = inst_valid ? (inst_pc + XLEN'(4)) : '0;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: variable-latency memory model, a scoreboard
// of expected {pc, inst} entries, a reset-release vector table and corner sequences.
module tb_fetch_prefetch_queue;

   localparam int XLEN   = 64;
   localparam int INST_W = 32;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              imem_req;
   logic [XLEN-1:0]   imem_addr;
   logic              imem_ack;
   logic [INST_W-1:0] imem_rdata;
   logic              redirect_valid = 1'b0;
   logic [XLEN-1:0]   redirect_pc = '0;
   logic              inst_valid;
   logic [INST_W-1:0] inst;
   logic [XLEN-1:0]   inst_pc;
   logic [XLEN-1:0]   inst_pc4;
   logic              inst_ready = 1'b0;

   always #5 clk = ~clk;

   fetch_prefetch_queue #(
      .XLEN     (XLEN),
      .INST_W   (INST_W),
      .DEPTH    (DEPTH),
      .RESET_PC (64'h0)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_pc4       (inst_pc4),
      .inst_ready     (inst_ready)
   );

   // Memory model: acks once the request has waited mem_latency cycles.
   int mem_latency = 0;
   int wait_cnt;
   always @(posedge clk or negedge reset) begin
      if (!reset)                      wait_cnt <= 0;
      else if (imem_req && imem_ack)   wait_cnt <= 0;
      else if (imem_req)               wait_cnt <= wait_cnt + 1;
   end
   assign imem_ack   = imem_req && (wait_cnt >= mem_latency);
   assign imem_rdata = 32'h0000_0013 | imem_addr[31:0];

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end else begin
         $display("ok   %s = %h", nm, act);
      end
   endtask

   // Scoreboard: at each negedge, check the head, then apply what the next edge does.
   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] ins;
   } ent_t;
   ent_t        sb_q[$];
   ent_t        sb_e;
   logic [63:0] m_fetch_pc = 64'h0;
   bit          m_drain = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            sb_q.delete();
            m_fetch_pc = 64'h0;
            m_drain    = 1'b0;
         end else begin
            chk("sb_valid", {63'd0, inst_valid}, {63'd0, sb_q.size() != 0});
            if (inst_valid && sb_q.size() != 0) begin
               chk("sb_inst", {32'd0, inst}, {32'd0, sb_q[0].ins});
               chk("sb_pc",   inst_pc,  sb_q[0].pc);
               chk("sb_pc4",  inst_pc4, sb_q[0].pc + 64'd4);
            end
            if (redirect_valid) begin
               sb_q.delete();
               if (imem_req) m_drain = !imem_ack;
               m_fetch_pc = redirect_pc & ~64'h3;
            end else begin
               if (inst_valid && inst_ready && sb_q.size() != 0) void'(sb_q.pop_front());
               if (imem_req && imem_ack) begin
                  if (m_drain) begin
                     m_drain = 1'b0;
                  end else begin
                     chk("sb_req_addr", imem_addr, m_fetch_pc);
                     sb_e.pc  = m_fetch_pc;
                     sb_e.ins = 32'h0000_0013 | m_fetch_pc[31:0];
                     sb_q.push_back(sb_e);
                     m_fetch_pc = m_fetch_pc + 64'd4;
                  end
               end
               if (sb_q.size() > DEPTH) chk("sb_overflow", 64'(sb_q.size()), 64'(DEPTH));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset          = 1'b0;
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("rst_req",  {63'd0, imem_req},   64'd0);
      chk("rst_addr", imem_addr,           64'h0);
      chk("rst_valid",{63'd0, inst_valid}, 64'd0);
      chk("rst_inst", {32'd0, inst},       64'd0);
      chk("rst_pc",   inst_pc,             64'd0);
      chk("rst_pc4",  inst_pc4,            64'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   typedef struct {
      logic        ready;
      logic        req;
      logic [63:0] addr;
      logic        valid;
      logic [63:0] pc;
   } vec_t;
   vec_t tbl[6];

   initial begin
      // Row i is checked at the negedge following edge i after reset release.
      tbl[0] = '{1'b1, 1'b0, 64'd0,  1'b0, 64'd0};
      tbl[1] = '{1'b1, 1'b1, 64'd0,  1'b0, 64'd0};
      tbl[2] = '{1'b1, 1'b1, 64'd4,  1'b1, 64'd0};
      tbl[3] = '{1'b1, 1'b1, 64'd8,  1'b1, 64'd4};
      tbl[4] = '{1'b1, 1'b1, 64'd12, 1'b1, 64'd8};
      tbl[5] = '{1'b1, 1'b1, 64'd16, 1'b1, 64'd12};

      // Reset release, zero-wait memory, decode always ready.
      mem_latency = 0;
      inst_ready  = 1'b1;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
         end
         inst_ready = tbl[i].ready;
         @(negedge clk);
         chk($sformatf("tbl%0d_req", i),   {63'd0, imem_req},   {63'd0, tbl[i].req});
         chk($sformatf("tbl%0d_addr", i),  imem_addr,           tbl[i].addr);
         chk($sformatf("tbl%0d_valid", i), {63'd0, inst_valid}, {63'd0, tbl[i].valid});
         if (tbl[i].valid) begin
            chk($sformatf("tbl%0d_pc", i),  inst_pc,  tbl[i].pc);
            chk($sformatf("tbl%0d_pc4", i), inst_pc4, tbl[i].pc + 64'd4);
         end
      end

      // Backpressure: four pushes then req drops; one pop re-issues at 16.
      inst_ready = 1'b0;
      do_reset();
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("bp_req_low", {63'd0, imem_req}, 64'd0);
      chk("bp_head_pc", inst_pc, 64'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_no_extra_req", {63'd0, imem_req}, 64'd0);
      end
      @(posedge clk);
      #1;
      inst_ready = 1'b1;
      @(posedge clk);
      #1;
      inst_ready = 1'b0;
      @(negedge clk);
      chk("bp_req_again", {63'd0, imem_req}, 64'd1);
      chk("bp_addr16",    imem_addr,         64'd16);
      @(negedge clk);
      chk("bp_req_full", {63'd0, imem_req}, 64'd0);
      chk("bp_head_pc4", inst_pc,           64'd4);

      // Three-cycle latency: address held, entry one cycle after ack, no duplicate.
      mem_latency = 3;
      inst_ready  = 1'b0;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk("lat_req",  {63'd0, imem_req},   64'd1);
         chk("lat_addr", imem_addr,           64'd0);
         chk("lat_ack",  {63'd0, imem_ack},   64'd0);
         chk("lat_valid",{63'd0, inst_valid}, 64'd0);
      end
      @(negedge clk);
      chk("lat_ack_now",   {63'd0, imem_ack},   64'd1);
      chk("lat_not_yet",   {63'd0, inst_valid}, 64'd0);
      @(negedge clk);
      chk("lat_valid_now", {63'd0, inst_valid}, 64'd1);
      chk("lat_pc",        inst_pc,             64'd0);
      chk("lat_next_addr", imem_addr,           64'd4);
      @(posedge clk);
      #1;
      inst_ready = 1'b1;
      repeat (12) @(posedge clk);
      #1;

      // Redirect while a request is outstanding: DRAIN, stale data dropped.
      mem_latency = 1;
      inst_ready  = 1'b0;
      do_reset();
      repeat (5) @(posedge clk);
      #1;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h200;
      @(negedge clk);
      chk("drn_setup_valid", {63'd0, inst_valid}, 64'd1);
      chk("drn_setup_noack", {63'd0, imem_ack},   64'd0);
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("drn_flushed",  {63'd0, inst_valid}, 64'd0);
      chk("drn_req_held", {63'd0, imem_req},   64'd1);
      chk("drn_addr_held",imem_addr,           64'd8);
      @(negedge clk);
      chk("drn_idle_req", {63'd0, imem_req},   64'd0);
      chk("drn_no_data",  {63'd0, inst_valid}, 64'd0);
      @(negedge clk);
      chk("drn_new_req",  {63'd0, imem_req},   64'd1);
      chk("drn_new_addr", imem_addr,           64'h200);
      begin
         int budget = 10;
         while (!inst_valid && budget > 0) begin
            @(negedge clk);
            budget--;
         end
         chk("drn_target_valid", {63'd0, inst_valid}, 64'd1);
         chk("drn_target_pc",    inst_pc,             64'h200);
      end

      // Redirect to an unaligned target on the same edge as ack and pop.
      mem_latency = 0;
      inst_ready  = 1'b1;
      do_reset();
      repeat (4) @(posedge clk);
      #1;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h103;
      @(negedge clk);
      chk("same_setup_valid", {63'd0, inst_valid}, 64'd1);
      chk("same_setup_ack",   {63'd0, imem_ack},   64'd1);
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("same_empty",  {63'd0, inst_valid}, 64'd0);
      chk("same_no_req", {63'd0, imem_req},   64'd0);
      @(negedge clk);
      chk("same_req",  {63'd0, imem_req}, 64'd1);
      chk("same_addr", imem_addr,         64'h100);
      @(negedge clk);
      chk("same_pc",   inst_pc,             64'h100);
      chk("same_inst", {32'd0, inst},       64'h113);

      // Asynchronous reset with three entries queued.
      inst_ready = 1'b0;
      do_reset();
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("arst_valid", {63'd0, inst_valid}, 64'd0);
      chk("arst_req",   {63'd0, imem_req},   64'd0);
      chk("arst_addr",  imem_addr,           64'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("arst_restart_req",  {63'd0, imem_req}, 64'd1);
      chk("arst_restart_addr", imem_addr,         64'd0);

      // PC wrap at the top of the address space.
      mem_latency = 0;
      inst_ready  = 1'b1;
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 64'hFFFF_FFFF_FFFF_FFF8;
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("wrap_pc0", inst_pc, 64'hFFFF_FFFF_FFFF_FFF8);
      @(negedge clk);
      chk("wrap_pc1",  inst_pc,  64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_pc4",  inst_pc4, 64'h0);
      @(negedge clk);
      chk("wrap_pc2", inst_pc, 64'h0);

      // Random ready, redirects and latency; the scoreboard checks every cycle.
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         if (i % 50 == 0) mem_latency = int'($urandom_range(0, 2));
         inst_ready     = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_pc    = {$urandom, $urandom};
      end
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      inst_ready     = 1'b1;
      repeat (20) @(posedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
- Upstream neighbour of the single-cycle core's fetch and decode path.
- Issues sequential instruction-memory reads and buffers returned instructions with their PCs in a small FIFO.
- Presents them to decode through a valid/ready handshake.
- Flushes and restarts fetch on a branch/jump redirect from execute.
- Tolerates a variable-latency instruction memory with at most one outstanding request.

Parameters:
- XLEN, 64, PC/address width
- INST_W, 32, instruction width
- DEPTH, 4, FIFO entries (power of two, at least 2)
- RESET_PC, 64'h0, first fetch address after reset

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- imem_req  output  1  read request, registered
- imem_addr  output  XLEN  read address, registered, word aligned
- imem_ack  input  1  memory has accepted and answered the current request this cycle
- imem_rdata  input  INST_W  instruction data, valid when imem_ack=1
- redirect_valid  input  1  taken branch/jump: flush and refetch
- redirect_pc  input  XLEN  redirect target
- inst_valid  output  1  FIFO head is valid
- inst  output  INST_W  head instruction
- inst_pc  output  XLEN  head PC
- inst_pc4  output  XLEN  head PC + 4
- inst_ready  input  1  decode consumes the head this cycle

Behaviour:
- Reset (reset=0, asynchronous):
  - imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC.
  - FIFO count=0, so inst_valid=0; inst, inst_pc, inst_pc4 read as 0.
  - FSM=IDLE.
- Handshake rules:
  - A request is the cycle(s) where imem_req=1. imem_addr is stable while req=1 and ack=0.
  - imem_ack is only meaningful when imem_req=1. Zero-wait memories may ack in the same cycle req rises.
  - Pop occurs at an edge where inst_valid=1 and inst_ready=1.
  - Push occurs at an edge where imem_ack=1, FSM=WAIT and redirect_valid=0. It writes {imem_addr, imem_rdata} and sets fetch_pc=imem_addr+4.
- FSM states:
  - IDLE: no request outstanding. Go to WAIT and raise req with addr=fetch_pc when count_next < DEPTH and redirect_valid=0.
  - WAIT: request outstanding, response will be kept.
    - ack with space still free after push/pop: stay in WAIT, req=1, addr+=4 (back-to-back).
    - ack with FIFO becoming full: go to IDLE, req=0.
    - redirect_valid without ack: go to DRAIN, req stays 1, addr held.
  - DRAIN: request outstanding, response will be discarded. On ack go to IDLE, req=0, data dropped.
- count_next = count + push - pop. The FIFO never overflows; a request is never issued without a guaranteed free slot.
- Latency:
  - With zero-wait memory, first req=1 one cycle after reset release.
  - inst_valid=1 one cycle after the first ack.
  - Sustained throughput is 1 instruction/cycle while inst_ready=1.
- Redirect (redirect_valid=1 at an edge):
  - FIFO flushed (count=0, inst_valid=0 next cycle); a simultaneous pop is ignored.
  - fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - Same edge as ack: data discarded, FSM goes to IDLE, the new request issues next cycle.
  - Outstanding with no ack: go to DRAIN.
  - Redirect while in DRAIN: only the target is updated.
  - Redirect while in IDLE: the new request issues next cycle.
- Wrap-around:
  - FIFO pointers wrap modulo DEPTH.
  - fetch_pc wraps modulo 2^XLEN with no flag.
- Reset mid-operation: all state returns to reset values immediately. Any in-flight memory response after reset release is not expected (memory shares the reset).

Decomposition:
- Shared package fetch_pkg:
  - XLEN, INST_W and RESET_PC defaults.
  - FSM encodings IDLE=2'd0, WAIT=2'd1, DRAIN=2'd2.
  - FIFO entry packing {pc, inst} as a named width constant.
- One sub-module: fetch_fifo.
  - Synchronous FIFO with parameters WIDTH and DEPTH, ports push, pop, flush, count and head.
  - Asynchronous active-low reset.
  - Flush has priority over push and pop.

Test Plan:
- Reset release with imem_ack tied 1 and imem_rdata = 32'h00000013 | addr -> req rises cycle 1 at addr 0. inst_valid cycle 2 with inst_pc=0, inst_pc4=4. Then PCs 4, 8, 12 on consecutive cycles.
- Backpressure: inst_ready=0, zero-wait memory -> exactly 4 pushes (PCs 0..12), then req=0. Raise inst_ready for 1 cycle -> one pop, one new request at addr 16.
- Variable latency, ack after 3 cycles -> imem_addr held at 0 for all 3 cycles. The entry appears one cycle after ack; no duplicate push.
- Redirect to 64'h200 while a request is outstanding (no ack) -> FIFO empties and FSM enters DRAIN. The late ack's data never appears on inst. The next request goes out at 64'h200.
- Redirect to 64'h103 on the same edge as ack and pop -> ack data dropped, pop ignored, FIFO empty. The next request is at 64'h100.
- Assert reset mid-stream with 3 entries queued -> inst_valid=0 and imem_req=0 asynchronously. After release, fetch restarts at RESET_PC.
